// File: rtl/scmem_pkg.sv
// Shared definitions for the data-memory side of the single-cycle CPU:
// store-buffer sizing, the buffered entry layout and the word-address slice.
package scmem_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 5;

  // Word address is taken from byte address bits [WA_MSB:WA_LSB]
  localparam int WA_LSB = 2;
  localparam int WA_MSB = SB_AW + 1;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/scstorebuf_if.sv
// CPU/RAM-facing bus of the store buffer. The master side is the environment
// (CPU datapath plus RAM), the slave side is the store buffer itself.
interface scstorebuf_if #(
  parameter int DEPTH = scmem_pkg::SB_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_we;
  logic          cpu_re;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_datain;
  logic [31:0]   mem_dataout;
  logic          sb_empty;
  logic [CW-1:0] sb_count;

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_dataout,
    input  cpu_rdata, stall, mem_we, mem_addr, mem_datain, sb_empty, sb_count
  );

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_dataout,
    output cpu_rdata, stall, mem_we, mem_addr, mem_datain, sb_empty, sb_count
  );

endinterface

// File: rtl/scstorebuf_fwd.sv
// Store-to-load forwarding search: finds the youngest valid buffered entry
// whose word address matches the load. Purely combinational.
module scstorebuf_fwd
  import scmem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [SB_AW-1:0]           laddr,
  output logic                       hit,
  output logic [31:0]                hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from the newest slot (tail-1) towards the oldest; first match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(i + 1);
      if (!hit && valid[idx] && (entries[idx].addr == laddr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/scstorebuf.sv
// Posted-write store buffer between the CPU load/store path and the data RAM.
// Stores retire into a small FIFO in one cycle and drain to the RAM on cycles
// without a load; loads see the youngest buffered value for their word.
module scstorebuf
  import scmem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input logic         clk,
  input logic         clrn,
  scstorebuf_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             enq;
  logic             drain;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    load_waddr;
  logic             hit;
  logic [31:0]      hit_data;

  // Occupancy is tracked by count alone, so head==tail is never ambiguous
  assign full       = (count_q == CW'(DEPTH));
  assign enq        = sb.cpu_we & ~full;
  assign drain      = (count_q != '0) & ~sb.cpu_re;
  assign load_waddr = sb.cpu_addr[AW+1:WA_LSB];

  // Stall is deliberately conservative: a same-cycle drain does not free a slot
  assign sb.stall    = sb.cpu_we & full;
  assign sb.sb_empty = (count_q == '0);
  assign sb.sb_count = count_q;

  // Pointers and occupancy; a reset drops every pending store
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PW'(1);
      if (drain) head_q <= head_q + PW'(1);
      case ({enq, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail_q].addr <= sb.cpu_addr[AW+1:WA_LSB];
      entries[tail_q].data <= sb.cpu_wdata;
    end
  end

  // Slot j is live when its distance from head is below the occupancy
  always_comb begin
    valid = '0;
    for (int j = 0; j < DEPTH; j++) begin
      valid[j] = ({1'b0, PW'(j) - head_q} < count_q);
    end
  end

  scstorebuf_fwd #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries  (entries),
    .valid    (valid),
    .tail     (tail_q),
    .laddr    (load_waddr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // Load data: buffered value wins over the RAM copy
  assign sb.cpu_rdata = hit ? hit_data : sb.mem_dataout;

  // RAM port: the head entry owns it whenever no load is using it
  always_comb begin
    sb.mem_we     = drain;
    sb.mem_addr   = sb.cpu_addr;
    sb.mem_datain = sb.cpu_wdata;
    if (drain) begin
      sb.mem_addr   = {{(30-AW){1'b0}}, entries[head_q].addr, 2'b00};
      sb.mem_datain = entries[head_q].data;
    end
  end

endmodule

// File: tb/tb_scstorebuf.sv
// Self-checking bench for scstorebuf. The reference model is a queue of
// pending stores plus an image of what the RAM should hold.
module tb_scstorebuf;
  import scmem_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic clrn;

  scstorebuf_if #(.DEPTH(DEPTH)) bus ();

  scstorebuf #(
    .DEPTH (DEPTH),
    .AW    (SB_AW)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .sb   (bus.slave)
  );

  logic [31:0] ram     [32];
  logic [31:0] ref_ram [32];

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } st_t;

  st_t q[$];

  int n_tests;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_dataout = ram[bus.mem_addr[6:2]];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[6:2]] = bus.mem_datain;
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == addr[6:2]) return q[i].d;
    return ref_ram[addr[6:2]];
  endfunction

  function automatic logic exp_mem_we();
    return clrn && (q.size() > 0) && !bus.cpu_re;
  endfunction

  function automatic logic [31:0] exp_mem_addr();
    if (exp_mem_we()) return {25'd0, q[0].a, 2'b00};
    return bus.cpu_addr;
  endfunction

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    #1;
  endtask

  task automatic advance();
    bit   drn;
    bit   acc;
    st_t  e;
    drn = exp_mem_we();
    acc = clrn && bus.cpu_we && (q.size() < DEPTH);
    e.a = bus.cpu_addr[6:2];
    e.d = bus.cpu_wdata;
    @(posedge clk);
    if (drn) begin
      ref_ram[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h1);
    @(negedge clk);
    n_tests += 4;
    if (bus.sb_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_empty: got %b expected 1", bus.sb_empty); end
    if (bus.sb_count !== CW'(0)) begin n_fail++; $display("[TB] FAIL rst_count: got %0d expected 0", bus.sb_count); end
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stall: got %b expected 0", bus.stall); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    clrn = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h50, 32'h0);
    n_tests += 4;
    if (bus.cpu_rdata !== 32'ha3) begin n_fail++; $display("[TB] FAIL load_50: got %h expected 000000a3", bus.cpu_rdata); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL load_mem_we: got %b expected 0", bus.mem_we); end
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL load_stall: got %b expected 0", bus.stall); end
    if (bus.sb_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL load_empty: got %b expected 1", bus.sb_empty); end
    advance();
  endtask

  task automatic test_forward();
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h258);
    n_tests += 2;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_store_stall: got %b expected 0", bus.stall); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_store_mem_we: got %b expected 0", bus.mem_we); end
    advance();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h60, 32'h0);
      n_tests += 3;
      if (bus.cpu_rdata !== 32'h258) begin n_fail++; $display("[TB] FAIL fwd_rdata[%0d]: got %h expected 00000258", c, bus.cpu_rdata); end
      if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_mem_we[%0d]: got %b expected 0", c, bus.mem_we); end
      if (bus.sb_count !== CW'(1)) begin n_fail++; $display("[TB] FAIL fwd_count[%0d]: got %0d expected 1", c, bus.sb_count); end
      advance();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    n_tests += 3;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_drain_we: got %b expected 1", bus.mem_we); end
    if (bus.mem_addr !== 32'h60) begin n_fail++; $display("[TB] FAIL fwd_drain_addr: got %h expected 00000060", bus.mem_addr); end
    if (bus.mem_datain !== 32'h258) begin n_fail++; $display("[TB] FAIL fwd_drain_data: got %h expected 00000258", bus.mem_datain); end
    advance();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    n_tests += 3;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_after_we: got %b expected 0", bus.mem_we); end
    if (bus.sb_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_after_empty: got %b expected 1", bus.sb_empty); end
    if (ram[5'h18] !== 32'h258) begin n_fail++; $display("[TB] FAIL fwd_ram18: got %h expected 00000258", ram[5'h18]); end
  endtask

  task automatic test_youngest();
    logic [31:0] e;
    e = exp_rdata(32'h54);
    applyStimulus(1'b1, 1'b1, 32'h54, 32'h11);
    n_tests++;
    if (bus.cpu_rdata !== e) begin n_fail++; $display("[TB] FAIL yng_same_cycle: got %h expected %h", bus.cpu_rdata, e); end
    advance();
    applyStimulus(1'b1, 1'b1, 32'h54, 32'h22);
    n_tests++;
    if (bus.cpu_rdata !== 32'h11) begin n_fail++; $display("[TB] FAIL yng_older: got %h expected 00000011", bus.cpu_rdata); end
    advance();
    applyStimulus(1'b0, 1'b1, 32'h57, 32'h0);
    n_tests++;
    if (bus.cpu_rdata !== 32'h22) begin n_fail++; $display("[TB] FAIL yng_load: got %h expected 00000022", bus.cpu_rdata); end
    advance();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      advance();
    end
    n_tests++;
    if (ram[5'h15] !== 32'h22) begin n_fail++; $display("[TB] FAIL yng_ram15: got %h expected 00000022", ram[5'h15]); end
  endtask

  task automatic test_full_stall();
    logic [31:0] d [5];
    for (int k = 0; k < 5; k++) d[k] = $urandom;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h20 + 32'(4 * k), d[k]);
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL full_stall[%0d]: got %b expected 0", k, bus.stall); end
      advance();
    end
    applyStimulus(1'b1, 1'b0, 32'h30, d[4]);
    n_tests += 3;
    if (bus.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall5: got %b expected 1", bus.stall); end
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL full_drain5: got %b expected 1", bus.mem_we); end
    if (bus.mem_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL full_addr5: got %h expected 00000020", bus.mem_addr); end
    advance();
    applyStimulus(1'b1, 1'b0, 32'h30, d[4]);
    n_tests += 2;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL full_retry_stall: got %b expected 0", bus.stall); end
    if (bus.sb_count !== CW'(3)) begin n_fail++; $display("[TB] FAIL full_retry_count: got %0d expected 3", bus.sb_count); end
    advance();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      n_tests++;
      if (bus.mem_addr !== exp_mem_addr()) begin n_fail++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", c, bus.mem_addr, exp_mem_addr()); end
      advance();
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (ram[5'h8 + 5'(k)] !== d[k]) begin n_fail++; $display("[TB] FAIL full_ram[%0d]: got %h expected %h", k, ram[5'h8 + 5'(k)], d[k]); end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b1, 32'h5c, 32'hdead);
    advance();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'hbeef);
    advance();
    applyStimulus(1'b1, 1'b1, 32'h44, 32'hcafe);
    advance();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    clrn = 1'b0;
    #1;
    q.delete();
    n_tests += 2;
    if (bus.sb_count !== CW'(0)) begin n_fail++; $display("[TB] FAIL mid_count: got %0d expected 0", bus.sb_count); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_mem_we: got %b expected 0", bus.mem_we); end
    advance();
    clrn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      advance();
    end
    applyStimulus(1'b0, 1'b1, 32'h5c, 32'h0);
    n_tests += 2;
    if (bus.cpu_rdata !== 32'h115) begin n_fail++; $display("[TB] FAIL mid_load5c: got %h expected 00000115", bus.cpu_rdata); end
    if (ram[5'h10] !== ref_ram[5'h10]) begin n_fail++; $display("[TB] FAIL mid_ram10: got %h expected %h", ram[5'h10], ref_ram[5'h10]); end
    advance();
  endtask

  task automatic test_wrap();
    applyStimulus(1'b1, 1'b0, {25'd0, 5'($urandom), 2'b00}, $urandom);
    advance();
    for (int c = 0; c < DEPTH + 2; c++) begin
      applyStimulus(1'b1, 1'b0, {25'd0, 5'($urandom), 2'b00}, $urandom);
      n_tests += 4;
      if (bus.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_we[%0d]: got %b expected 1", c, bus.mem_we); end
      if (bus.mem_addr !== exp_mem_addr()) begin n_fail++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", c, bus.mem_addr, exp_mem_addr()); end
      if (bus.mem_datain !== q[0].d) begin n_fail++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", c, bus.mem_datain, q[0].d); end
      if (bus.sb_count !== CW'(1)) begin n_fail++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 1", c, bus.sb_count); end
      advance();
    end
  endtask

  task automatic test_random();
    logic we, re;
    logic [31:0] addr;
    for (int c = 0; c < 300; c++) begin
      we   = 1'($urandom);
      re   = ($urandom_range(0, 2) == 0);
      addr = {25'd0, 5'($urandom_range(0, 7) + 8), 2'($urandom)};
      applyStimulus(we, re, addr, $urandom);
      n_tests += 4;
      if (bus.stall !== (we && q.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_stall[%0d]: got %b expected %b", c, bus.stall, (we && q.size() == DEPTH)); end
      if (bus.mem_we !== exp_mem_we()) begin n_fail++; $display("[TB] FAIL rnd_mem_we[%0d]: got %b expected %b", c, bus.mem_we, exp_mem_we()); end
      if (bus.mem_addr !== exp_mem_addr()) begin n_fail++; $display("[TB] FAIL rnd_mem_addr[%0d]: got %h expected %h", c, bus.mem_addr, exp_mem_addr()); end
      if (bus.sb_count !== CW'(q.size())) begin n_fail++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", c, bus.sb_count, q.size()); end
      if (re) begin
        n_tests++;
        if (bus.cpu_rdata !== exp_rdata(addr)) begin n_fail++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", c, bus.cpu_rdata, exp_rdata(addr)); end
      end
      if (exp_mem_we()) begin
        n_tests++;
        if (bus.mem_datain !== q[0].d) begin n_fail++; $display("[TB] FAIL rnd_datain[%0d]: got %h expected %h", c, bus.mem_datain, q[0].d); end
      end
      advance();
    end
  endtask

  task automatic test_final_ram();
    for (int c = 0; c < DEPTH + 2; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      advance();
    end
    n_tests++;
    if (bus.sb_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL final_empty: got %b expected 1", bus.sb_empty); end
    for (int w = 0; w < 32; w++) begin
      n_tests++;
      if (ram[w] !== ref_ram[w]) begin n_fail++; $display("[TB] FAIL final_ram[%0d]: got %h expected %h", w, ram[w], ref_ram[w]); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int w = 0; w < 32; w++) begin
      ram[w]     = 32'h1000 + 32'(w);
      ref_ram[w] = 32'h1000 + 32'(w);
    end
    ram[5'h14]     = 32'ha3;
    ref_ram[5'h14] = 32'ha3;
    ram[5'h17]     = 32'h115;
    ref_ram[5'h17] = 32'h115;
    clrn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    test_reset();
    test_forward();
    test_youngest();
    test_full_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    test_final_ram();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
